// File: rtl/rgbw_pwm_engine.sv
// Four-channel (R,G,B,W) 8-bit PWM with double-buffered duties applied at the period wrap
// and phase-staggered channels to spread LED turn-on current.
module rgbw_pwm_engine #(
    parameter int PHASE_STEP = 64,
    parameter bit OUT_POL    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_half,
    input  logic       ld,
    input  logic [7:0] duty_r,
    input  logic [7:0] duty_g,
    input  logic [7:0] duty_b,
    input  logic [7:0] duty_w,
    input  logic       out_en,
    output logic       busy,
    output logic       period_done,
    output logic       red_pin,
    output logic       green_pin,
    output logic       blue_pin,
    output logic       white_pin
);

    localparam logic PIN_IDLE = ~OUT_POL;

    logic [7:0]      cnt;
    logic [3:0][7:0] pending;
    logic [3:0][7:0] active;
    logic [3:0][7:0] duty_in;
    logic [3:0][7:0] ph;
    logic [3:0]      raw;
    logic [3:0]      pin;
    logic            wrap;

    assign duty_in = {duty_w, duty_b, duty_g, duty_r};
    assign wrap    = clk_half && (cnt == 8'hFF);

    // Each channel compares a rotated copy of the shared counter against its duty.
    always_comb begin
        ph  = '0;
        raw = '0;
        for (int i = 0; i < 4; i++) begin
            ph[i]  = cnt + 8'(i * PHASE_STEP);
            raw[i] = (ph[i] < active[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            pending     <= '0;
            active      <= '0;
            busy        <= 1'b0;
            period_done <= 1'b0;
        end else begin
            if (clk_half)
                cnt <= cnt + 8'd1;
            period_done <= wrap;
            if (wrap) begin
                // A load landing on the wrap bypasses the buffer and goes live immediately.
                if (ld)
                    active <= duty_in;
                else if (busy)
                    active <= pending;
                busy <= 1'b0;
            end else if (ld) begin
                pending <= duty_in;
                busy    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pin <= {4{PIN_IDLE}};
        else
            pin <= out_en ? (raw ^ {4{PIN_IDLE}}) : {4{PIN_IDLE}};
    end

    assign red_pin   = pin[0];
    assign green_pin = pin[1];
    assign blue_pin  = pin[2];
    assign white_pin = pin[3];

endmodule
